// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding, default widths and counter sizing for the BRAM port arbiter.
package bram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_W = 2'd1,
    OWN_R = 2'd2
  } state_t;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 8;
  localparam int RD_LAT_DEF    = 1;
  localparam int MAX_BURST_DEF = 16;
  function automatic int cnt_w(input int m);
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/rd_valid_pipe.sv
// rd_valid_pipe: RD_LAT-deep valid shift register tracking reads in flight inside the BRAM.
module rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic valid
);
  logic [RD_LAT-1:0] sr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= RD_LAT'({sr, issue});
  end
  assign valid = sr[RD_LAT-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: writer-priority request/grant arbiter for one BRAM port with bounded bursts
// and a read-valid pipeline matched to BRAM latency.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_req,
  output logic              w_gnt,
  input  logic              w_ena,
  input  logic              w_wea,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_din,
  input  logic              r_req,
  output logic              r_gnt,
  input  logic              r_ena,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_dout,
  output logic              r_dvalid,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              err_drop
);
  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
  localparam bit PREEMPT = MAX_BURST != 0;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic own_w, own_r, inc, full;

  assign own_w = state == OWN_W;
  assign own_r = state == OWN_R;
  assign w_gnt = own_w;
  assign r_gnt = own_r;
  assign inc   = own_w ? w_ena : own_r ? r_ena : 1'b0;
  // Looks one access ahead so the handover lands on the edge of the MAX_BURST-th access.
  assign full  = PREEMPT && (cnt == MAX_C || (inc && cnt == MAX_C - 1'b1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = w_req ? OWN_W : r_req ? OWN_R : IDLE;
      OWN_W:   state_nxt = !w_req ? (r_req ? OWN_R : IDLE) : (full && r_req) ? OWN_R : OWN_W;
      OWN_R:   state_nxt = !r_req ? (w_req ? OWN_W : IDLE) : (full && w_req) ? OWN_W : OWN_R;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt != state) ? '0 : (PREEMPT && inc && cnt != MAX_C) ? cnt + 1'b1 : cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      err_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      err_drop <= err_drop | (w_ena & ~own_w) | (r_ena & ~own_r);
    end
  end

  always_comb begin
    bram_ena  = own_w ? w_ena  : own_r ? r_ena  : 1'b0;
    bram_wea  = own_w & w_wea;
    bram_addr = own_w ? w_addr : own_r ? r_addr : '0;
    bram_din  = own_w ? w_din  : '0;
  end

  assign r_dout = bram_dout;

  rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (
    .clk   (clk),
    .reset (reset),
    .issue (r_ena & own_r),
    .valid (r_dvalid)
  );
endmodule
